// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// rf_wb_pkg : shared types and constants for the register-file write-back path
// Rev 1.0
// ============================================================================
package rf_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_FIFO = 2'd2
  } sel_e;

endpackage
`default_nettype wire

// File: rtl/rf_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// rf_writeback_arbiter_if : ALU / LSU result inputs and register-file write port
// busy_regs is present only when WB_SCOREBOARD_EN is defined.  Rev 1.0
// ============================================================================
interface rf_writeback_arbiter_if;
  import rf_wb_pkg::*;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_stall;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wdata;
`ifdef WB_SCOREBOARD_EN
  logic [2**REG_AW-1:0] busy_regs;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_stall, lsu_ready, rf_we, rf_rd, rf_wdata
`ifdef WB_SCOREBOARD_EN
    , input busy_regs
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_stall, lsu_ready, rf_we, rf_rd, rf_wdata
`ifdef WB_SCOREBOARD_EN
    , output busy_regs
`endif
  );

endinterface
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// ============================================================================
// rf_wb_fifo : synchronous FIFO of write-back requests, no fall-through
// Rev 1.0
// ============================================================================
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic    clk,
  input  wire logic    rst,
  input  wire logic    i_push,
  input  wire wb_req_t i_din,
  input  wire logic    i_pop,
  output logic         o_full,
  output logic         o_empty,
  output wb_req_t      o_head
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// rf_writeback_arbiter : merges ALU and buffered LSU/MUL results onto the RF
// write port. Optional busy_regs scoreboard under WB_SCOREBOARD_EN.  Rev 1.0
// ============================================================================
module rf_writeback_arbiter
  import rf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  rf_writeback_arbiter_if.slave  wb
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  sel_e              w_sel;
  wb_req_t           w_head;
  wb_req_t           w_lsu_req;
  wb_req_t           w_win;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_stall;
  logic [SW-1:0]     r_starve;
  logic              r_we;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_wdata;

  assign w_lsu_req = '{rd: wb.lsu_rd, data: wb.lsu_data};
  assign w_push    = wb.lsu_valid && !w_full;
  assign w_stall   = (r_starve == SW'(STARVE_MAX));
  assign w_pop     = (w_sel == SEL_FIFO);

  rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_din   (w_lsu_req),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_comb begin
    w_sel = SEL_NONE;
    if (w_stall && !w_empty)  w_sel = SEL_FIFO;
    else if (wb.alu_valid)    w_sel = SEL_ALU;
    else if (!w_empty)        w_sel = SEL_FIFO;
  end

  always_comb begin
    w_win = w_head;
    if (w_sel == SEL_ALU) w_win = '{rd: wb.alu_rd, data: wb.alu_data};
  end

  // Counts cycles the FIFO head has been passed over; saturation forces one pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (!w_stall) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= (w_sel != SEL_NONE) && (w_win.rd != '0);
      if (w_sel != SEL_NONE) begin
        r_rd    <= w_win.rd;
        r_wdata <= w_win.data;
      end
    end
  end

  assign wb.alu_stall = w_stall;
  assign wb.lsu_ready = !w_full;
  assign wb.rf_we     = r_we;
  assign wb.rf_rd     = r_rd;
  assign wb.rf_wdata  = r_wdata;

`ifdef WB_SCOREBOARD_EN
  localparam int NREG = 2**REG_AW;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  logic [NREG-1:0] w_busy;

  assign w_busy[0] = 1'b0;

  // One occupancy counter per register: entries in the FIFO targeting it.
  for (genvar r = 1; r < NREG; r++) begin : g_sb
    logic [CW-1:0] r_cnt;
    logic          w_inc;
    logic          w_dec;

    assign w_inc = w_push && (wb.lsu_rd == REG_AW'(r));
    assign w_dec = w_pop && (w_head.rd == REG_AW'(r));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_busy[r] = |r_cnt;
  end

  assign wb.busy_regs = w_busy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_writeback_arbiter : scoreboard bench for rf_writeback_arbiter
// Rev 1.0
// ============================================================================
module tb_rf_writeback_arbiter;
  import rf_wb_pkg::*;

  localparam int STARVE_MAX = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;
  logic alu_acc;
  logic lsu_acc;
  int   alu_n;
  int   lsu_i;
  int   stall_at;
  logic [XLEN-1:0] held;
  wb_req_t q_alu[$];
  wb_req_t q_lsu[$];

  rf_writeback_arbiter_if wb ();

  rf_writeback_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    wb.alu_valid = 1'b0;
    wb.alu_rd    = '0;
    wb.alu_data  = '0;
    wb.lsu_valid = 1'b0;
    wb.lsu_rd    = '0;
    wb.lsu_data  = '0;
  endtask

  // Record what the handshakes accept this cycle, then advance to the next negedge.
  task automatic tick();
    alu_acc = wb.alu_valid && !wb.alu_stall;
    lsu_acc = wb.lsu_valid && wb.lsu_ready;
    if (alu_acc && wb.alu_rd != '0) q_alu.push_back('{rd: wb.alu_rd, data: wb.alu_data});
    if (lsu_acc && wb.lsu_rd != '0) q_lsu.push_back('{rd: wb.lsu_rd, data: wb.lsu_data});
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    idle();
    for (int i = 0; i < 60 && (q_alu.size() != 0 || q_lsu.size() != 0); i++) @(negedge clk);
    check(tag, 64'(q_alu.size() + q_lsu.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // LSU results carry tag nibble 0xB in their data; everything else is ALU traffic.
  always @(negedge clk) begin
    wb_req_t e;
    if (!reset && wb.rf_we) begin
      if (wb.rf_wdata[31:28] == 4'hB) begin
        if (q_lsu.size() == 0) check("lsu_unexpected_write", 64'd1, 64'd0);
        else begin
          e = q_lsu.pop_front();
          check("lsu_rd", 64'(wb.rf_rd), 64'(e.rd));
          check("lsu_data", 64'(wb.rf_wdata), 64'(e.data));
        end
      end else begin
        if (q_alu.size() == 0) check("alu_unexpected_write", 64'd1, 64'd0);
        else begin
          e = q_alu.pop_front();
          check("alu_rd", 64'(wb.rf_rd), 64'(e.rd));
          check("alu_data", 64'(wb.rf_wdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    alu_n    = 0;
    reset    = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    check("rst_we", 64'(wb.rf_we), 64'd0);
    check("rst_rd", 64'(wb.rf_rd), 64'd0);
    check("rst_wdata", 64'(wb.rf_wdata), 64'd0);
    check("rst_stall", 64'(wb.alu_stall), 64'd0);
    check("rst_ready", 64'(wb.lsu_ready), 64'd1);
`ifdef WB_SCOREBOARD_EN
    check("rst_busy", 64'(wb.busy_regs), 64'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // ALU only: one-cycle registered latency, then rd/wdata hold.
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 5'd5;
    wb.alu_data  = 32'hDEADBEEF;
    check("t1_stall_pre", 64'(wb.alu_stall), 64'd0);
    tick();
    idle();
    check("t1_we", 64'(wb.rf_we), 64'd1);
    check("t1_rd", 64'(wb.rf_rd), 64'd5);
    check("t1_wdata", 64'(wb.rf_wdata), 64'hDEADBEEF);
    check("t1_stall_post", 64'(wb.alu_stall), 64'd0);
    tick();
    check("t1_hold_we", 64'(wb.rf_we), 64'd0);
    check("t1_hold_rd", 64'(wb.rf_rd), 64'd5);
    check("t1_hold_wdata", 64'(wb.rf_wdata), 64'hDEADBEEF);

    // x0 destinations: selected but never written.
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 5'd0;
    wb.alu_data  = 32'h0000_1234;
    tick();
    idle();
    check("t2_alu_x0_we", 64'(wb.rf_we), 64'd0);
    wb.lsu_valid = 1'b1;
    wb.lsu_rd    = 5'd0;
    wb.lsu_data  = 32'hB000_0000;
    check("t2_lsu_ready", 64'(wb.lsu_ready), 64'd1);
    tick();
    idle();
    tick();
    check("t2_lsu_x0_we", 64'(wb.rf_we), 64'd0);
`ifdef WB_SCOREBOARD_EN
    check("t2_busy_x0", 64'(wb.busy_regs), 64'd0);
`endif
    drain("t2_drain");

    // Fill to full under continuous ALU traffic; 5th offer waits for a pop.
    lsu_i = 0;
    for (int c = 0; c < 40; c++) begin
      wb.alu_valid = (c < 30);
      wb.alu_rd    = REG_AW'(10 + alu_n % 8);
      wb.alu_data  = 32'hA300_0000 | 32'(alu_n);
      wb.lsu_valid = (lsu_i < 5);
      wb.lsu_rd    = REG_AW'(20 + lsu_i);
      wb.lsu_data  = 32'hB300_0000 | 32'(lsu_i);
      tick();
      if (alu_acc) alu_n++;
      if (lsu_acc) begin
        lsu_i++;
        if (lsu_i == 4) check("t3_full_ready", 64'(wb.lsu_ready), 64'd0);
      end
    end
    check("t3_all_pushed", 64'(lsu_i), 64'd5);
    drain("t3_drain");

    // Starvation: head waits STARVE_MAX cycles, then one stall cycle forces the pop.
    stall_at = -1;
    held     = '0;
    for (int c = 0; c < 14; c++) begin
      wb.alu_valid = 1'b1;
      wb.alu_rd    = 5'd9;
      wb.alu_data  = 32'hA400_0000 | 32'(alu_n);
      wb.lsu_valid = (c == 0);
      wb.lsu_rd    = 5'd7;
      wb.lsu_data  = 32'hB400_0007;
      if (stall_at >= 0 && c == stall_at + 1)
        check("t4_stall_one_cycle", 64'(wb.alu_stall), 64'd0);
      if (wb.alu_stall && stall_at < 0) begin
        stall_at = c;
        held     = wb.alu_data;
        check("t4_stall_cycle", 64'(c), 64'(STARVE_MAX + 1));
      end
      tick();
      if (alu_acc) alu_n++;
      if (stall_at >= 0 && c == stall_at) begin
        check("t4_pop_we", 64'(wb.rf_we), 64'd1);
        check("t4_pop_rd", 64'(wb.rf_rd), 64'd7);
      end
      if (stall_at >= 0 && c == stall_at + 1)
        check("t4_held_data", 64'(wb.rf_wdata), 64'(held));
    end
    check("t4_stall_seen", 64'(stall_at >= 0), 64'd1);
    drain("t4_drain");

    // Reset mid-cycle with three results buffered: none of them may be written.
    for (int c = 0; c < 3; c++) begin
      wb.alu_valid = 1'b1;
      wb.alu_rd    = 5'd2;
      wb.alu_data  = 32'hA500_0000 | 32'(alu_n);
      wb.lsu_valid = 1'b1;
      wb.lsu_rd    = REG_AW'(11 + c);
      wb.lsu_data  = 32'hB500_0000 | 32'(c);
      tick();
      if (alu_acc) alu_n++;
    end
    idle();
    #2 reset = 1'b1;
    #1;
    check("t5_we", 64'(wb.rf_we), 64'd0);
    check("t5_ready", 64'(wb.lsu_ready), 64'd1);
    q_alu.delete();
    q_lsu.delete();
    #1 reset = 1'b0;
    repeat (15) @(negedge clk);
    check("t5_ready_after", 64'(wb.lsu_ready), 64'd1);
    check("t5_rd_cleared", 64'(wb.rf_rd), 64'd0);

`ifdef WB_SCOREBOARD_EN
    // Two in-flight writes to x3 keep its busy bit up until the second pop.
    wb.lsu_valid = 1'b1;
    wb.lsu_rd    = 5'd3;
    wb.lsu_data  = 32'hB600_0003;
    tick();
    check("t6_busy_first", 64'(wb.busy_regs), 64'h8);
    wb.lsu_data  = 32'hB600_0103;
    tick();
    idle();
    check("t6_busy_second", 64'(wb.busy_regs), 64'h8);
    tick();
    check("t6_busy_clear", 64'(wb.busy_regs), 64'd0);
    drain("t6_drain");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
